// File: rtl/reg_mon_pkg.sv
// Shared defaults, width helpers and the event record for the register change monitor.
package reg_mon_pkg;

    localparam int NUM_REGS_DEF   = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int HOLD_W_DEF     = 16;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int IGNORE_R0_DEF  = 1;

    // Index width never drops below one bit so a single-channel build still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(NUM_REGS_DEF);

    typedef struct packed {
        logic [IDX_W_DEF-1:0]  index;
        logic [DATA_W_DEF-1:0] data;
    } evt_t;

endpackage

// File: rtl/reg_change_monitor_if.sv
// Event stream from the monitor: first-word-fall-through head plus occupancy.
interface reg_change_monitor_if
    import reg_mon_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
);
    localparam int IDX_W = idx_width(NUM_REGS);
    localparam int CNT_W = cnt_width(FIFO_DEPTH);

    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_index;
    logic [DATA_W-1:0] evt_data;
    logic [CNT_W-1:0] evt_count;

    modport master (
        output evt_valid,
        output evt_index,
        output evt_data,
        output evt_count,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_index,
        input  evt_data,
        input  evt_count,
        output evt_ready
    );

endinterface

// File: rtl/reg_change_monitor_evt_fifo.sv
// Small first-word-fall-through queue of change events with synchronous flush.
module evt_fifo
    import reg_mon_pkg::*;
#(
    parameter int  DEPTH = FIFO_DEPTH_DEF,
    parameter type T     = evt_t
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [cnt_width(DEPTH)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = cnt_width(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign count   = count_reg;

    // Gating the head keeps the outputs at zero whenever nothing is queued.
    assign pop_data = empty ? T'('0) : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/reg_change_monitor.sv
// Watches a register file, highlights changed channels and queues {index, value}
// events for a consumer, lowest pending channel first.
module reg_change_monitor
    import reg_mon_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int HOLD_W     = HOLD_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int IGNORE_R0  = IGNORE_R0_DEF
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_in,
    input  logic [HOLD_W-1:0]                hold_cycles,
    input  logic                             sticky,
    input  logic [NUM_REGS-1:0]              ack_mask,
    input  logic                             resync,
    output logic [NUM_REGS-1:0]              changed_mask,
    output logic                             coalesced,
    reg_change_monitor_if.master             evt
);
    localparam int IDX_W = idx_width(NUM_REGS);
    localparam int CNT_W = cnt_width(FIFO_DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } mon_evt_t;

    logic [NUM_REGS-1:0][DATA_W-1:0] shadow_val;
    logic [NUM_REGS-1:0]             change;
    logic [NUM_REGS-1:0]             pending_reg;
    logic [NUM_REGS-1:0]             pending_next;
    logic                            coalesced_reg;
    logic                            coalesced_next;

    logic [IDX_W-1:0]    push_idx;
    logic [NUM_REGS-1:0] push_onehot;
    logic                push;
    logic                pop;
    mon_evt_t            push_entry;
    mon_evt_t            head_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_ch
            logic [DATA_W-1:0] shadow_reg;
            logic [HOLD_W-1:0] cnt_reg;
            logic              mask_reg;

            if (gi == 0 && IGNORE_R0 != 0) begin : g_r0_masked
                assign change[gi] = 1'b0;
            end else begin : g_live
                assign change[gi] = (regs_in[gi] != shadow_reg);
            end

            assign shadow_val[gi]   = shadow_reg;
            assign changed_mask[gi] = mask_reg;

            // Sticky mode parks cnt at zero so leaving it drops the mask on the next edge.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    shadow_reg <= '0;
                    cnt_reg    <= '0;
                    mask_reg   <= 1'b0;
                end else begin
                    shadow_reg <= regs_in[gi];
                    if (resync) begin
                        cnt_reg  <= '0;
                        mask_reg <= 1'b0;
                    end else if (sticky) begin
                        cnt_reg <= '0;
                        if (change[gi])        mask_reg <= 1'b1;
                        else if (ack_mask[gi]) mask_reg <= 1'b0;
                    end else if (change[gi]) begin
                        cnt_reg  <= hold_cycles;
                        mask_reg <= 1'b1;
                    end else if (cnt_reg != '0) begin
                        cnt_reg  <= cnt_reg - 1'b1;
                        mask_reg <= 1'b1;
                    end else begin
                        mask_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Lowest-index pending channel wins the single push slot each cycle.
    always_comb begin
        push_idx    = '0;
        push_onehot = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                push_idx    = IDX_W'(i);
                push_onehot = '0;
                push_onehot[i] = 1'b1;
            end
        end
    end

    assign pop  = !fifo_empty && evt.evt_ready;
    assign push = (pending_reg != '0) && (!fifo_full || pop) && !resync;

    always_comb begin
        push_entry       = '0;
        push_entry.index = push_idx;
        push_entry.data  = shadow_val[push_idx];
    end

    // A change landing on the channel being pushed keeps it pending for a fresh event.
    always_comb begin
        pending_next   = pending_reg;
        coalesced_next = coalesced_reg;
        if (resync) begin
            pending_next   = '0;
            coalesced_next = 1'b0;
        end else begin
            if (push) pending_next = pending_next & ~push_onehot;
            pending_next = pending_next | change;
            if ((change & pending_reg) != '0) coalesced_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg   <= '0;
            coalesced_reg <= 1'b0;
        end else begin
            pending_reg   <= pending_next;
            coalesced_reg <= coalesced_next;
        end
    end

    evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (mon_evt_t)
    ) u_evt_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (resync),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign coalesced     = coalesced_reg;
    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_index = head_entry.index;
    assign evt.evt_data  = head_entry.data;
    assign evt.evt_count = fifo_count;

endmodule

// File: doc/reg_change_monitor.md
REG_CHANGE_MONITOR -- requirements
Module: reg_change_monitor

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, number of monitored registers.
REQ-002 The block SHALL have parameter DATA_W, default 32, register width.
REQ-003 The block SHALL have parameter HOLD_W, default 16, width of the hold counter.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 8, power of two, depth of the event queue.
REQ-005 The block SHALL have parameter IGNORE_R0, default 1, which masks channel 0 (x0) when set.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  the single clock
- reset_n  in  1  asynchronous active-low reset
- regs_in  in  NUM_REGS x DATA_W  live register-file contents
- hold_cycles  in  HOLD_W  extra highlight cycles in hold mode
- sticky  in  1  mode select: 0 = hold, 1 = sticky until ack
- ack_mask  in  NUM_REGS  per-channel clear in sticky mode
- resync  in  1  re-baseline the shadow copy without flagging
- changed_mask  out  NUM_REGS  per-channel highlight
- evt_valid  out  1  event queue non-empty
- evt_ready  in  1  consumer accepts the head event
- evt_index  out  clog2(NUM_REGS)  channel of the head event
- evt_data  out  DATA_W  value of the head event
- evt_count  out  clog2(FIFO_DEPTH)+1  queue occupancy
- coalesced  out  1  sticky flag: a change hit an already-pending channel

Function
REQ-007 Per channel: change[i] = (regs_in[i] != shadow[i]); at every edge, shadow[i] SHALL be loaded with regs_in[i].
REQ-008 With IGNORE_R0=1, change[0] SHALL be forced to 0.
REQ-009 Hold mode, at the edge where change[i]=1:
- changed_mask[i] <= 1 and cnt[i] <= hold_cycles.
- Otherwise, if cnt[i] > 0: cnt[i] decrements and the mask stays 1.
- Otherwise the mask is 0.
- Result: the mask is high for hold_cycles+1 cycles; hold_cycles=0 gives a one-cycle pulse.
REQ-010 A re-change during the hold SHALL reload cnt[i] to hold_cycles.
REQ-011 Sticky mode: change[i] sets changed_mask[i], and ack_mask[i] clears it.
REQ-012 In sticky mode, a simultaneous change and ack on the same channel SHALL leave the mask set (change wins).
REQ-013 A runtime toggle of sticky SHALL take effect on the next edge.
REQ-014 On leaving sticky mode, set masks SHALL be cleared by the hold-mode rule, with cnt = 0.
REQ-015 change[i] SHALL set pending[i] at the same edge.
REQ-016 If pending[i] is already 1 when change[i] occurs, coalesced SHALL be set; no second event is produced.
REQ-017 Each cycle, if pending != 0 and the queue can accept, the lowest-index pending channel SHALL be pushed as {index, shadow[index]} and its pending bit cleared.
- The queue can accept when count < FIFO_DEPTH, or when the queue is full and a pop happens in the same cycle.
REQ-018 If a change and a push hit the same channel in the same cycle, pending SHALL remain set and the pushed data SHALL be the old shadow value.
REQ-019 Latency: regs_in changes before edge E0; mask and pending are set at E0; the push happens at E1; evt_valid is high after E1.
REQ-020 The queue SHALL be first-word-fall-through: evt_valid = (count != 0), and evt_index/evt_data present the head entry.
REQ-021 A pop SHALL occur when evt_valid && evt_ready; evt_ready while empty SHALL have no effect.
REQ-022 A simultaneous push and pop SHALL leave count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-023 When the queue is full, changes SHALL accumulate in pending without loss.
REQ-024 resync=1 SHALL, at the edge:
- load shadow <= regs_in;
- clear pending, cnt, changed_mask, the queue, and coalesced.
REQ-025 resync SHALL take priority over all changes, pushes, pops and acks in the same cycle.

Reset
REQ-026 reset_n=0 SHALL asynchronously clear shadow, cnt, pending, changed_mask, the queue pointers, evt_count and coalesced.
- evt_valid SHALL read 0 throughout reset.
REQ-027 After reset deassertion, any non-zero regs_in[i] SHALL register as a change on the first edge.
REQ-028 A reset asserted mid-hold or mid-drain SHALL discard all state with no partial event.

Structure
REQ-029 Package reg_mon_pkg SHALL hold:
- the parameter defaults;
- the evt_t struct {index, data};
- the clog2-derived width constants.
REQ-030 The event queue SHALL be the sub-module evt_fifo, parametrised on FIFO_DEPTH and evt_t, with push/pop/full/empty/count.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Hold, hold_cycles=3: regs_in[5] 0 -> 0x1234 -> mask[5] high exactly 4 cycles; one event {5, 0x1234}.
- Sticky: regs_in[7] changes -> mask[7] stays high 100 cycles; ack_mask[7] and a change on 7 in the same cycle -> mask stays 1; a lone ack clears it next edge.
- Burst: regs 1,2,3 change in one cycle -> events in order 1,2,3 on consecutive cycles with evt_ready=1; regs_in[0] change with IGNORE_R0 -> no event, mask[0]=0.
- Full: evt_ready=0, 10 distinct channels change, FIFO_DEPTH=8 -> count=8, 2 pending; release evt_ready -> all 10 delivered, coalesced=0.
- Coalesce: regs_in[4] changes twice while pending/blocked -> one event with the latest value, coalesced=1; resync clears coalesced, queue and masks with no new event.
- Reset mid-hold with queue count=5 -> all outputs 0 immediately; first edge after release flags every non-zero register.
